// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Brief    : Opcode result select, status flags and 2-entry valid/ready skid
//            buffer at the ALU output, plus sticky overflow and delivery count.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] and_y,
    input  logic [WIDTH-1:0] or_y,
    input  logic [WIDTH-1:0] inv_y,
    input  logic [WIDTH-1:0] arith_y,
    input  logic             arith_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Entry layout: {illegal, ovf, neg, zero, result}
    localparam int ENT_W = WIDTH + 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] skid;
    logic [ENT_W-1:0] cap_entry;
    logic [WIDTH-1:0] cap_result;
    logic             cap_ovf;
    logic             cap_illegal;
    logic             accept;
    logic             deliver;
    logic             load_head_in;
    logic             load_skid;
    logic             move_skid;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        cap_result  = '0;
        cap_ovf     = 1'b0;
        cap_illegal = 1'b0;
        case (op_sel)
            3'b000,
            3'b001:  begin
                cap_result = arith_y;
                cap_ovf    = arith_ovf;
            end
            3'b010:  cap_result = and_y;
            3'b011:  cap_result = or_y;
            3'b100:  cap_result = inv_y;
            default: cap_illegal = 1'b1;
        endcase
    end

    assign cap_entry = {cap_illegal, cap_ovf, cap_result[WIDTH-1],
                        (cap_result == '0), cap_result};

    always_comb begin
        state_nxt    = state;
        load_head_in = 1'b0;
        load_skid    = 1'b0;
        move_skid    = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (!accept && deliver) begin
                    state_nxt = EMPTY;
                end else if (accept && deliver) begin
                    load_head_in = 1'b1;
                end
            end
            TWO: begin
                if (deliver) begin
                    state_nxt = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            head       <= '0;
            skid       <= '0;
            ovf_sticky <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load_head_in) begin
                head <= cap_entry;
            end else if (move_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= cap_entry;
            end
            // Setting has priority over a simultaneous clear
            if (deliver && head[WIDTH+2]) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (deliver) begin
                xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_result  = head[WIDTH-1:0];
    assign out_zero    = head[WIDTH];
    assign out_neg     = head[WIDTH+1];
    assign out_ovf     = head[WIDTH+2];
    assign out_illegal = head[WIDTH+3];

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Brief    : Directed vector bench for alu_result_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_sel;
    logic [15:0] and_y;
    logic [15:0] or_y;
    logic [15:0] inv_y;
    logic [15:0] arith_y;
    logic        arith_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_ovf;
    logic        out_illegal;
    logic        ovf_sticky;
    logic        ovf_clr;
    logic [15:0] xfer_cnt;

    int          checks;
    int          errors;
    logic [15:0] exp_cnt;

    alu_result_stage #(.WIDTH(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_sel     (op_sel),
        .and_y      (and_y),
        .or_y       (or_y),
        .inv_y      (inv_y),
        .arith_y    (arith_y),
        .arith_ovf  (arith_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .out_illegal(out_illegal),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .xfer_cnt   (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a_and;
        logic [15:0] a_or;
        logic [15:0] a_inv;
        logic [15:0] a_ar;
        logic        a_ovf;
        logic [15:0] e_res;
        logic        e_zero;
        logic        e_neg;
        logic        e_ovf;
        logic        e_ill;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] o,
                        input logic [15:0] iv, input logic [15:0] ar, input logic ov);
        in_valid  = 1'b1;
        op_sel    = op;
        and_y     = a;
        or_y      = o;
        inv_y     = iv;
        arith_y   = ar;
        arith_ovf = ov;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 16'd0;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        op_sel = 3'b001; and_y = 16'hFFFF; or_y = 16'hFFFF; inv_y = 16'hFFFF;
        arith_y = 16'h8000; arith_ovf = 1'b1;

        //             op      and      or       inv      arith    aovf  res      z  n  o  i
        vecs[0] = '{3'b010, 16'h00F0, 16'h0F0F, 16'hAAAA, 16'h1234, 1'b1, 16'h00F0, 0, 0, 0, 0};
        vecs[1] = '{3'b011, 16'h0000, 16'h8001, 16'h5555, 16'h0000, 1'b0, 16'h8001, 0, 1, 0, 0};
        vecs[2] = '{3'b100, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h7777, 1'b0, 16'h0000, 1, 0, 0, 0};
        vecs[3] = '{3'b000, 16'h1111, 16'h2222, 16'h3333, 16'h7FFF, 1'b0, 16'h7FFF, 0, 0, 0, 0};
        vecs[4] = '{3'b001, 16'h0001, 16'h0002, 16'h0003, 16'h8000, 1'b1, 16'h8000, 0, 1, 1, 0};
        vecs[5] = '{3'b111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1, 0, 0, 1};
        vecs[6] = '{3'b101, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 1'b0, 16'h0000, 1, 0, 0, 1};
        vecs[7] = '{3'b000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 1, 0};

        // Reset with handshakes active: must be ignored
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_flags", {28'd0, out_zero, out_neg, out_ovf, out_illegal}, 32'd0);
        chk("rst_result", {16'd0, out_result}, 32'd0);
        chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Table: one entry per cycle, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].a_and, vecs[i].a_or, vecs[i].a_inv, vecs[i].a_ar, vecs[i].a_ovf);
            tick();
            if (i > 0) exp_cnt++;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), {16'd0, out_result}, {16'd0, vecs[i].e_res});
            chk($sformatf("vec%0d_flags", i), {28'd0, out_zero, out_neg, out_ovf, out_illegal},
                {28'd0, vecs[i].e_zero, vecs[i].e_neg, vecs[i].e_ovf, vecs[i].e_ill});
            chk($sformatf("vec%0d_cnt", i), {16'd0, xfer_cnt}, {16'd0, exp_cnt});
        end
        chk("tbl_sticky", {31'd0, ovf_sticky}, 32'd1);
        in_valid = 1'b0;
        tick();
        exp_cnt++;
        chk("tbl_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("tbl_drain_cnt", {16'd0, xfer_cnt}, {16'd0, exp_cnt});
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);

        // Back-pressure: fill both entries, third send must be dropped
        out_ready = 1'b0;
        send(3'b011, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 1'b0);
        tick();
        chk("bp1_ready", {31'd0, in_ready}, 32'd1);
        send(3'b100, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 1'b0);
        tick();
        chk("bp2_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2_hold", {16'd0, out_result}, 32'h1111);
        send(3'b010, 16'h3333, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        chk("bp3_ready", {31'd0, in_ready}, 32'd0);
        chk("bp3_hold", {16'd0, out_result}, 32'h1111);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_deq1_result", {16'd0, out_result}, 32'h2222);
        chk("bp_deq1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        exp_cnt++;
        chk("bp_deq2_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_cnt", {16'd0, xfer_cnt}, {16'd0, exp_cnt});

        // Streaming 0..7 on add
        for (int i = 0; i < 8; i++) begin
            send(3'b000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'(i), 1'b0);
            tick();
            if (i > 0) exp_cnt++;
            chk($sformatf("strm%0d_result", i), {16'd0, out_result}, i);
            chk($sformatf("strm%0d_zero", i), {31'd0, out_zero}, {31'd0, (i == 0)});
            chk($sformatf("strm%0d_hs", i), {30'd0, out_valid, in_ready}, 32'd3);
        end
        in_valid = 1'b0;
        tick();
        exp_cnt++;
        chk("strm_cnt", {16'd0, xfer_cnt}, {16'd0, exp_cnt});

        // Set and clear of sticky in the same cycle: set wins
        out_ready = 1'b0;
        send(3'b001, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        tick();
        exp_cnt++;
        chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
        tick();
        ovf_clr = 1'b0;
        chk("sticky_clr2", {31'd0, ovf_sticky}, 32'd0);

        // Counter wrap
        send(3'b010, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        begin
            int k;
            k = 0;
            while (exp_cnt != 16'hFFFF) begin
                tick();
                if (k > 0) exp_cnt++;
                k++;
            end
        end
        chk("cnt_max", {16'd0, xfer_cnt}, 32'h0000FFFF);
        in_valid = 1'b0;
        tick();
        exp_cnt++;
        chk("cnt_wrap", {16'd0, xfer_cnt}, 32'd0);

        // Reset while TWO entries are pending
        send(3'b001, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_sticky", {31'd0, ovf_sticky}, 32'd1);
        out_ready = 1'b0;
        send(3'b010, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        send(3'b011, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0);
        tick();
        chk("pre_rst_full", {30'd0, out_valid, in_ready}, 32'd2);
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_rst_hs", {30'd0, out_valid, in_ready}, 32'd1);
        chk("mid_rst_result", {16'd0, out_result}, 32'd0);
        chk("mid_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        chk("mid_rst_cnt", {16'd0, xfer_cnt}, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("after_rst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("after_rst_cnt", {16'd0, xfer_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
